// File: rtl/hc_csr_bank_if.sv
// rtl/hc_csr_bank_if.sv - CCI-P MMIO record types and the request/response bundle for hc_csr_bank
package hc_csr_bank_pkg;

  typedef logic [57:0] t_hc_address;

  typedef struct packed {
    t_hc_address address;
    logic [31:0] size;
  } t_hc_buffer;

  typedef struct packed {
    logic        mmio_rd_valid;
    logic        mmio_wr_valid;
    logic [15:0] address;
    logic [8:0]  tid;
    logic [63:0] data;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic        mmio_rd_valid;
    logic [8:0]  tid;
    logic [63:0] data;
  } t_if_ccip_c2_Tx;

endpackage

interface hc_csr_bank_if;
  import hc_csr_bank_pkg::*;

  t_if_ccip_c0_Rx c0_rx;
  t_if_ccip_c2_Tx afu_c2_tx;
  t_if_ccip_c2_Tx c2_tx;

  modport master (output c0_rx, output afu_c2_tx, input c2_tx);
  modport slave  (input c0_rx, input afu_c2_tx, output c2_tx);
endinterface

// File: rtl/hc_csr_bank.sv
// rtl/hc_csr_bank.sv - MMIO CSR bank with skid-buffered AFU response merge
// Optional build macro HC_CSR_PERF_CNT_EN adds BUSY_CYCLES/DONE_COUNT at 0x0F0/0x0F8.
module hc_csr_bank
  import hc_csr_bank_pkg::*;
#(
  parameter int           NUM_BUFFERS = 4,
  parameter logic [127:0] AFU_ID      = 128'h0,
  parameter int           SKID_DEPTH  = 2
) (
  input  logic                clk,
  input  logic                reset,
  hc_csr_bank_if.slave        mmio,
  input  logic                afu_busy,
  input  logic                afu_done,
  output logic                hc_start,
  output logic [31:0]         hc_control,
  output t_hc_address         hc_dsm_base,
  output t_hc_buffer          hc_buffer [NUM_BUFFERS]
);

  localparam logic [63:0] DFH   = 64'h1000_0000_0400_0000;
  localparam int          PTR_W = $clog2(SKID_DEPTH);
  localparam int          CNT_W = PTR_W + 1;

  // Register indices are 64-bit slots: byte offset / 8
  localparam logic [4:0] IDX_DFH     = 5'd0;
  localparam logic [4:0] IDX_ID_L    = 5'd1;
  localparam logic [4:0] IDX_ID_H    = 5'd2;
  localparam logic [4:0] IDX_DSM     = 5'd5;
  localparam logic [4:0] IDX_CONTROL = 5'd6;
  localparam logic [4:0] IDX_STATUS  = 5'd7;

  logic        s1_rd;
  logic        s1_wr;
  logic        s1_odd;
  logic [4:0]  s1_idx;
  logic [8:0]  s1_tid;
  logic [63:0] s1_data;
  logic        in_window;

  assign in_window = (mmio.c0_rx.address[15:6] == 10'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_rd   <= 1'b0;
      s1_wr   <= 1'b0;
      s1_odd  <= 1'b0;
      s1_idx  <= '0;
      s1_tid  <= '0;
      s1_data <= '0;
    end else begin
      s1_rd   <= mmio.c0_rx.mmio_rd_valid && in_window;
      s1_wr   <= mmio.c0_rx.mmio_wr_valid && in_window && !mmio.c0_rx.address[0];
      s1_odd  <= mmio.c0_rx.address[0];
      s1_idx  <= mmio.c0_rx.address[5:1];
      s1_tid  <= mmio.c0_rx.tid;
      s1_data <= mmio.c0_rx.data;
    end
  end

  logic wr_dsm;
  logic wr_control;
  logic wr_status;
  logic start_req;

  assign wr_dsm     = s1_wr && (s1_idx == IDX_DSM);
  assign wr_control = s1_wr && (s1_idx == IDX_CONTROL);
  assign wr_status  = s1_wr && (s1_idx == IDX_STATUS);
  assign start_req  = wr_control && s1_data[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hc_start    <= 1'b0;
      hc_control  <= '0;
      hc_dsm_base <= '0;
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        hc_buffer[i] <= '0;
      end
    end else begin
      hc_start <= start_req;
      if (wr_dsm) begin
        hc_dsm_base <= s1_data[63:6];
      end
      if (wr_control) begin
        hc_control <= s1_data[31:0];
      end
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        if (s1_wr && (s1_idx == 5'(8 + 2 * i))) begin
          hc_buffer[i].address <= s1_data[63:6];
        end
        if (s1_wr && (s1_idx == 5'(9 + 2 * i))) begin
          hc_buffer[i].size <= s1_data[31:0];
        end
      end
    end
  end

  // Skid FIFO for AFU-originated responses
  logic [8:0]       fifo_tid  [SKID_DEPTH];
  logic [63:0]      fifo_data [SKID_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             pop;
  logic             push;
  logic             push_drop;

  assign pop       = (fifo_cnt != '0) && !s1_rd;
  assign push      = mmio.afu_c2_tx.mmio_rd_valid && ((fifo_cnt != CNT_W'(SKID_DEPTH)) || pop);
  assign push_drop = mmio.afu_c2_tx.mmio_rd_valid && !push;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_tid[wr_ptr]  <= mmio.afu_c2_tx.tid;
      fifo_data[wr_ptr] <= mmio.afu_c2_tx.data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Sticky status: a done pulse beats a same-edge clear
  logic st_done;
  logic st_ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_done <= 1'b0;
      st_ovf  <= 1'b0;
    end else begin
      if (afu_done) begin
        st_done <= 1'b1;
      end else if ((wr_status && s1_data[1]) || start_req) begin
        st_done <= 1'b0;
      end
      if (push_drop) begin
        st_ovf <= 1'b1;
      end else if (wr_status && s1_data[2]) begin
        st_ovf <= 1'b0;
      end
    end
  end

`ifdef HC_CSR_PERF_CNT_EN
  logic [63:0] busy_cycles;
  logic [63:0] done_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_cycles <= '0;
      done_count  <= '0;
    end else if (start_req) begin
      busy_cycles <= '0;
      done_count  <= '0;
    end else begin
      if (afu_busy && !(&busy_cycles)) begin
        busy_cycles <= busy_cycles + 64'd1;
      end
      if (afu_done && !(&done_count)) begin
        done_count <= done_count + 64'd1;
      end
    end
  end
`endif

  logic [63:0] rd_data;

  always_comb begin
    rd_data = '0;
    if (!s1_odd) begin
      case (s1_idx)
        IDX_DFH:     rd_data = DFH;
        IDX_ID_L:    rd_data = AFU_ID[63:0];
        IDX_ID_H:    rd_data = AFU_ID[127:64];
        IDX_DSM:     rd_data = {hc_dsm_base, 6'b0};
        IDX_CONTROL: rd_data = {32'b0, hc_control};
        IDX_STATUS:  rd_data = {61'b0, st_ovf, st_done, afu_busy};
`ifdef HC_CSR_PERF_CNT_EN
        5'd30:       rd_data = busy_cycles;
        5'd31:       rd_data = done_count;
`endif
        default: begin
          for (int i = 0; i < NUM_BUFFERS; i++) begin
            if (s1_idx == 5'(8 + 2 * i)) begin
              rd_data = {hc_buffer[i].address, 6'b0};
            end
            if (s1_idx == 5'(9 + 2 * i)) begin
              rd_data = {32'b0, hc_buffer[i].size};
            end
          end
        end
      endcase
    end
  end

  t_if_ccip_c2_Tx c2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c2_q <= '0;
    end else if (s1_rd) begin
      c2_q <= {1'b1, s1_tid, rd_data};
    end else if (pop) begin
      c2_q <= {1'b1, fifo_tid[rd_ptr], fifo_data[rd_ptr]};
    end else begin
      c2_q <= '0;
    end
  end

  assign mmio.c2_tx = c2_q;

endmodule
